// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath: operand feeders,
// PE array top and result drain.
package mm_pkg;

    localparam int unsigned MM_D_W = 8;  // operand width per lane
    localparam int unsigned MM_N   = 4;  // lanes = array rows / columns
    localparam int unsigned MM_K   = 4;  // beats per dot product

    typedef logic [MM_D_W-1:0] lane_t;

    typedef struct packed {
        lane_t data;
        logic  init;
        logic  vld;
    } token_t;

    // Counter width for a modulo-depth counter; a depth of 1 still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain used to skew one feeder lane.
// DEPTH = 0 is a combinational pass-through.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_chain
        logic [W-1:0] pipe [DEPTH];

        // Shift the chain every cycle; clear all stages on reset
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int unsigned s = 0; s < DEPTH; s++) pipe[s] <= '0;
            end else begin
                pipe[0] <= d;
                for (int unsigned s = 1; s < DEPTH; s++) pipe[s] <= pipe[s-1];
            end
        end

        assign q = pipe[DEPTH-1];
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for one edge of the PE systolic array. Accepts one N-lane
// column per beat, marks the first beat of each K-beat group with init and
// skews lane i by i cycles. A flush request injects one zero beat with init
// on every lane at the next group boundary to drain the final PE sums.
module systolic_skew_feeder
    import mm_pkg::*;
#(
    parameter int unsigned D_W = MM_D_W,
    parameter int unsigned N   = MM_N,
    parameter int unsigned K   = MM_K
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N*D_W-1:0] s_data,
    input  logic             flush,
    output logic [N*D_W-1:0] out_data,
    output logic [N-1:0]     out_init,
    output logic             busy
);

    localparam int unsigned   KW     = cnt_w(K);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    logic [KW-1:0]    kcnt, kcnt_next;
    logic             flush_pending, flush_pending_next;
    logic             rst_released;
    logic             serve, accept;
    logic [N*D_W-1:0] s0_data, s0_data_next;
    logic             s0_init, s0_init_next, s0_vld_next;
    // vld_sr[j] flags a real token (beat or flush) held j stages past stage 0
    logic [N-1:0]     vld_sr;

    assign serve   = flush_pending & (kcnt == '0);
    assign s_ready = rst_released & ~serve;
    assign accept  = s_valid & s_ready;
    assign busy    = (kcnt != '0) | flush_pending | (|vld_sr);

    // Select the stage-0 token and advance group count / flush request
    always_comb begin
        s0_data_next       = '0;
        s0_init_next       = 1'b0;
        s0_vld_next        = 1'b0;
        kcnt_next          = kcnt;
        flush_pending_next = flush_pending | flush;
        if (serve) begin
            // flush beat: zero operands, init on every lane
            s0_init_next       = 1'b1;
            s0_vld_next        = 1'b1;
            flush_pending_next = 1'b0;
        end else if (accept) begin
            s0_data_next = s_data;
            s0_init_next = (kcnt == '0);
            s0_vld_next  = 1'b1;
            kcnt_next    = (kcnt == K_LAST) ? '0 : kcnt + KW'(1);
        end
    end

    // Control state, stage-0 register and occupancy shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kcnt          <= '0;
            flush_pending <= 1'b0;
            rst_released  <= 1'b0;
            s0_data       <= '0;
            s0_init       <= 1'b0;
            vld_sr        <= '0;
        end else begin
            kcnt          <= kcnt_next;
            flush_pending <= flush_pending_next;
            rst_released  <= 1'b1;
            s0_data       <= s0_data_next;
            s0_init       <= s0_init_next;
            vld_sr[0]     <= s0_vld_next;
            for (int unsigned j = 1; j < N; j++) vld_sr[j] <= vld_sr[j-1];
        end
    end

    // Lane i trails stage 0 by i further registers
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [D_W:0] tap;

        skew_delay_line #(
            .DEPTH(i),
            .W    (D_W + 1)
        ) u_dly (
            .clk(clk),
            .rst(rst),
            .d  ({s0_data[i*D_W +: D_W], s0_init}),
            .q  (tap)
        );

        assign out_data[i*D_W +: D_W] = tap[D_W:1];
        assign out_init[i]            = tap[0];
    end

endmodule
